// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
//   state_e      : timer FSM state encoding (2 bits)
//   SEC_TENS_MAX : wrap value of the seconds-tens digit
//   DIGIT_MAX    : wrap value of the ones and minutes-tens digits
//   SEC_MAX      : largest loadable seconds value
//   to_bcd()     : binary 0..99 to two packed BCD digits {tens, ones}
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [6:0] SEC_MAX      = 7'd59;

  // Caller guarantees v <= 99, so both results fit in one BCD digit.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter with synchronous load and borrow chaining.
//   clk, n_rst : clock, asynchronous active-high reset (digit -> 0)
//   dec_en     : decrement this digit by one
//   load_en    : copy load_val into the digit (wins over dec_en)
//   load_val   : value to load
//   wrap_val   : value the digit takes when decremented from 0
//   digit      : registered digit value
//   borrow_out : dec_en while digit is 0; drives the next digit's dec_en
module bcd_digit_down (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dec_en,
  input  logic       load_en,
  input  logic [3:0] load_val,
  input  logic [3:0] wrap_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_d;
  logic [3:0] digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load_en) begin
      digit_d = load_val;
    end else if (dec_en) begin
      digit_d = (digit_q == 4'd0) ? wrap_val : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// User-presettable MM:SS countdown driven by a once-per-second tick.
//   clk, n_rst          : clock, asynchronous active-high reset
//   second_tick         : one-cycle pulse per second
//   load                : load clamped preset, return to idle (highest priority)
//   start_stop          : toggle run / pause; starts from idle when count != 00:00
//   preset_min/sec      : binary preset, clamped to MAX_MINUTES:59
//   min_tens..sec_ones  : registered BCD count
//   running             : high while counting
//   done                : high while expired
//   expire              : one-cycle pulse on entry to the expired state
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned MAX_MINUTES = 99
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       second_tick,
  input  logic       load,
  input  logic       start_stop,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       expire
);

  localparam logic [6:0] MaxMin = 7'(MAX_MINUTES);

  state_e state_d, state_q;
  logic   running_q, done_q, expire_q;

  logic [6:0]  min_clamp;
  logic [6:0]  sec_clamp;
  logic [15:0] load_bcd;
  logic        count_zero;
  logic        count_one;
  logic        dec_en;
  logic [3:0]  borrow;

  // Preset clamping and binary -> BCD conversion.
  always_comb begin
    min_clamp = (preset_min > MaxMin) ? MaxMin : preset_min;
    sec_clamp = ({1'b0, preset_sec} > SEC_MAX) ? SEC_MAX : {1'b0, preset_sec};
    load_bcd  = {to_bcd(min_clamp), to_bcd(sec_clamp)};
  end

  assign count_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign count_one  = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // Zero gate keeps the count from wrapping below 00:00.
  assign dec_en = !load && second_tick && (state_q == StRunning) && !count_zero;

  bcd_digit_down u_sec_ones (
    .clk        (clk),
    .n_rst      (n_rst),
    .dec_en     (dec_en),
    .load_en    (load),
    .load_val   (load_bcd[3:0]),
    .wrap_val   (DIGIT_MAX),
    .digit      (sec_ones),
    .borrow_out (borrow[0])
  );

  bcd_digit_down u_sec_tens (
    .clk        (clk),
    .n_rst      (n_rst),
    .dec_en     (borrow[0]),
    .load_en    (load),
    .load_val   (load_bcd[7:4]),
    .wrap_val   (SEC_TENS_MAX),
    .digit      (sec_tens),
    .borrow_out (borrow[1])
  );

  bcd_digit_down u_min_ones (
    .clk        (clk),
    .n_rst      (n_rst),
    .dec_en     (borrow[1]),
    .load_en    (load),
    .load_val   (load_bcd[11:8]),
    .wrap_val   (DIGIT_MAX),
    .digit      (min_ones),
    .borrow_out (borrow[2])
  );

  bcd_digit_down u_min_tens (
    .clk        (clk),
    .n_rst      (n_rst),
    .dec_en     (borrow[2]),
    .load_en    (load),
    .load_val   (load_bcd[15:12]),
    .wrap_val   (DIGIT_MAX),
    .digit      (min_tens),
    .borrow_out (borrow[3])
  );

  // Priority: load > second_tick > start_stop.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_stop && !count_zero) state_d = StRunning;
        end
        StRunning: begin
          // A borrow out of the top digit would mean underflow; treat it as expiry too.
          if (second_tick && (count_one || borrow[3])) begin
            state_d = StExpired;
          end else if (start_stop) begin
            state_d = StPaused;
          end
        end
        StPaused: begin
          if (start_stop) state_d = StRunning;
        end
        StExpired: begin
          state_d = StExpired;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == StRunning);
      done_q    <= (state_d == StExpired);
      expire_q  <= (state_d == StExpired) && (state_q != StExpired);
    end
  end

  assign running = running_q;
  assign done    = done_q;
  assign expire  = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic       clk;
  logic       n_rst;
  logic       second_tick;
  logic       load;
  logic       start_stop;
  logic [6:0] preset_min;
  logic [5:0] preset_sec;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, expire;

  countdown_timer #(
    .MAX_MINUTES (99)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .second_tick (second_tick),
    .load        (load),
    .start_stop  (start_stop),
    .preset_min  (preset_min),
    .preset_sec  (preset_sec),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .done        (done),
    .expire      (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags are {running, done, expire}.
  localparam logic [2:0] FIdle = 3'b000;
  localparam logic [2:0] FRun  = 3'b100;
  localparam logic [2:0] FDone = 3'b010;
  localparam logic [2:0] FExp  = 3'b011;

  typedef struct {
    string       tag;
    logic [18:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [15:0] digits, input logic [2:0] flags);
    exp_t e;
    e.tag = tag;
    e.val = {digits, flags};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [18:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones, running, done, expire};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: got=%h/%b want=nothing", obs[18:3], obs[2:0]);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: got=%h/%b want=%h/%b", e.tag, obs[18:3], obs[2:0],
               e.val[18:3], e.val[2:0]);
      end
    end
  endtask

  // One clock cycle: drive inputs, record expectation, sample #1 after the edge.
  task automatic step(input logic t, input logic l, input logic s, input logic [6:0] pm,
                      input logic [5:0] ps, input string tag, input logic [15:0] d,
                      input logic [2:0] f);
    @(negedge clk);
    second_tick = t;
    load        = l;
    start_stop  = s;
    preset_min  = pm;
    preset_sec  = ps;
    push(tag, d, f);
    @(posedge clk);
    #1;
    second_tick = 1'b0;
    load        = 1'b0;
    start_stop  = 1'b0;
    check_out();
  endtask

  initial begin
    n_rst       = 1'b1;
    second_tick = 1'b0;
    load        = 1'b0;
    start_stop  = 1'b0;
    preset_min  = 7'd0;
    preset_sec  = 6'd0;
    #3;
    push("reset", 16'h0000, FIdle);
    check_out();
    @(negedge clk);
    n_rst = 1'b0;

    // Reset mid-run at 12:34.
    step(0, 1, 0, 7'd12, 6'd34, "load_1234", 16'h1234, FIdle);
    step(0, 0, 1, 7'd0,  6'd0,  "run_1234",  16'h1234, FRun);
    step(1, 0, 0, 7'd0,  6'd0,  "tick_1233", 16'h1233, FRun);
    @(negedge clk);
    #2;
    n_rst = 1'b1;
    #1;
    push("async_reset", 16'h0000, FIdle);
    check_out();
    @(posedge clk);
    #1;
    push("reset_hold", 16'h0000, FIdle);
    check_out();
    @(negedge clk);
    n_rst = 1'b0;
    step(0, 0, 1, 7'd0, 6'd0, "no_preset_kept", 16'h0000, FIdle);

    // 1:05 counting down across the minute boundary.
    step(0, 1, 0, 7'd1, 6'd5, "load_0105", 16'h0105, FIdle);
    step(1, 0, 0, 7'd0, 6'd0, "idle_tick", 16'h0105, FIdle);
    step(0, 0, 1, 7'd0, 6'd0, "start_0105", 16'h0105, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0104", 16'h0104, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0103", 16'h0103, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0102", 16'h0102, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0101", 16'h0101, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0100", 16'h0100, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0059", 16'h0059, FRun);
    step(0, 0, 0, 7'd0, 6'd0, "hold_0059", 16'h0059, FRun);

    // Expiry at 00:00 and stickiness.
    step(0, 1, 0, 7'd0, 6'd2, "load_0002", 16'h0002, FIdle);
    step(0, 0, 1, 7'd0, 6'd0, "start_0002", 16'h0002, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0001", 16'h0001, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "expire", 16'h0000, FExp);
    step(0, 0, 0, 7'd0, 6'd0, "done_held", 16'h0000, FDone);
    step(1, 0, 0, 7'd0, 6'd0, "exp_tick", 16'h0000, FDone);
    step(0, 0, 1, 7'd0, 6'd0, "exp_ss", 16'h0000, FDone);
    step(1, 0, 1, 7'd0, 6'd0, "exp_tick_ss", 16'h0000, FDone);

    // Tick with start_stop, pause, resume.
    step(0, 1, 0, 7'd0, 6'd10, "load_0010", 16'h0010, FIdle);
    step(0, 0, 1, 7'd0, 6'd0,  "start_0010", 16'h0010, FRun);
    step(1, 0, 1, 7'd0, 6'd0,  "tick_pause", 16'h0009, FIdle);
    step(1, 0, 0, 7'd0, 6'd0,  "paused_t1", 16'h0009, FIdle);
    step(1, 0, 0, 7'd0, 6'd0,  "paused_t2", 16'h0009, FIdle);
    step(1, 0, 0, 7'd0, 6'd0,  "paused_t3", 16'h0009, FIdle);
    step(1, 0, 1, 7'd0, 6'd0,  "resume_tick", 16'h0009, FRun);
    step(1, 0, 0, 7'd0, 6'd0,  "t_0008", 16'h0008, FRun);
    step(0, 0, 1, 7'd0, 6'd0,  "pause_alone", 16'h0008, FIdle);
    step(0, 0, 1, 7'd0, 6'd0,  "resume_alone", 16'h0008, FRun);

    // Tick with start_stop reaching 00:00 expires instead of pausing.
    step(0, 1, 0, 7'd0, 6'd1, "load_0001", 16'h0001, FIdle);
    step(0, 0, 1, 7'd0, 6'd0, "start_0001", 16'h0001, FRun);
    step(1, 0, 1, 7'd0, 6'd0, "tick_ss_exp", 16'h0000, FExp);
    step(0, 1, 0, 7'd0, 6'd3, "load_from_exp", 16'h0003, FIdle);

    // Clamping and full borrow chain.
    step(0, 1, 0, 7'd120, 6'd63, "clamp_9959", 16'h9959, FIdle);
    step(0, 1, 0, 7'd99,  6'd60, "clamp_sec60", 16'h9959, FIdle);
    step(0, 1, 0, 7'd45,  6'd59, "load_4559", 16'h4559, FIdle);
    step(0, 1, 0, 7'd10,  6'd0,  "load_1000", 16'h1000, FIdle);
    step(0, 0, 1, 7'd0,   6'd0,  "start_1000", 16'h1000, FRun);
    step(1, 0, 0, 7'd0,   6'd0,  "t_0959", 16'h0959, FRun);
    step(0, 1, 0, 7'd0,   6'd0,  "load_0000", 16'h0000, FIdle);
    step(0, 0, 1, 7'd0,   6'd0,  "start_zero", 16'h0000, FIdle);

    // Load wins over tick and start_stop.
    step(0, 1, 0, 7'd5, 6'd0, "load_0500", 16'h0500, FIdle);
    step(0, 0, 1, 7'd0, 6'd0, "start_0500", 16'h0500, FRun);
    step(1, 1, 0, 7'd5, 6'd0, "load_tick", 16'h0500, FIdle);
    step(1, 1, 1, 7'd7, 6'd30, "load_tick_ss", 16'h0730, FIdle);
    step(0, 0, 1, 7'd0, 6'd0, "start_0730", 16'h0730, FRun);
    step(1, 0, 0, 7'd0, 6'd0, "t_0729", 16'h0729, FRun);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Consumer of the one-per-second tick pulse: a user-presettable MM:SS countdown that decrements once per `second_tick` while running. It signals expiry when it reaches 00:00. It sits beside the stopwatch tick generator, in the opposite counting direction, and drives the same 4-digit BCD display path.

Parameters:
- MAX_MINUTES, 99, largest loadable minute value (1..99); larger presets clamp to it.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset; one clock; asynchronous, active-high (1 = reset)
- second_tick  in  1  one-cycle pulse per second from the tick generator
- load  in  1  pulse; copy the preset into the count and return to IDLE
- start_stop  in  1  pulse; toggles between run and pause
- preset_min  in  7  binary minutes 0..127
- preset_sec  in  6  binary seconds 0..63
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD count
- running  out  1  high in RUNNING
- done  out  1  level; high in EXPIRED
- expire  out  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset (async, n_rst=1):
  - state IDLE, all digits 0, running=0, done=0, expire=0.
- Outputs:
  - All outputs are registered.
  - Digits update the cycle after the qualifying tick or load.
  - expire is high exactly one cycle, the same cycle done first rises.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Priority each cycle: load > second_tick > start_stop.
- load (any state):
  - Count = clamp(preset_min, MAX_MINUTES) : clamp(preset_sec, 59), converted to BCD.
  - Next state IDLE; done=0.
  - Same-cycle tick and start_stop are ignored.
- IDLE:
  - start_stop with count != 00:00 -> RUNNING.
  - start_stop with count == 00:00 -> stay IDLE.
  - Ticks are ignored.
- RUNNING:
  - second_tick decrements by one second.
  - BCD borrow chain: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from min_ones; min_ones 0->9 borrows from min_tens.
  - Tick at 00:01 -> 00:00, next state EXPIRED, expire pulse.
  - start_stop alone -> PAUSED.
  - Tick and start_stop in the same cycle: the decrement is applied, then PAUSED. If that decrement reached 00:00, go EXPIRED instead.
- PAUSED:
  - Ticks are ignored.
  - start_stop -> RUNNING. A tick in that same cycle is not counted.
- EXPIRED:
  - Count holds 00:00; no wrap below zero.
  - start_stop and ticks are ignored.
  - Only load or reset leaves this state.
- Reset mid-run: immediate return to reset values; the preset is not retained.
- Invariant: digits are always valid BCD; sec_tens <= 5; count <= MAX_MINUTES:59.

Decomposition:
- Package countdown_pkg:
  - state enum type (2-bit).
  - constants SEC_TENS_MAX=5, DIGIT_MAX=9, SEC_MAX=59.
- Sub-module bcd_digit_down:
  - Ports: clk, n_rst, dec_en, load_en, load_val[3:0], wrap_val[3:0], digit[3:0], borrow_out.
  - borrow_out is asserted when dec_en and digit==0; the digit then wraps to wrap_val.
  - Four instances, chained by borrow.
- Top level holds the FSM, the binary->BCD preset conversion and clamping, and the zero detect.

Test Plan:
- Reset while running at 12:34 -> all digits 0, IDLE, done=0 in the same cycle reset asserts.
- load 1:05, start, 6 ticks -> 01:04, 01:03, 01:02, 01:01, 01:00, 00:59 (borrow across minutes).
- load 0:02, start, 2 ticks -> 00:00, expire high one cycle, done held; a third tick and start_stop leave 00:00 and EXPIRED.
- Run at 00:10; tick and start_stop in the same cycle -> 00:09 and PAUSED; 3 ticks -> still 00:09; start_stop with tick -> RUNNING, still 00:09.
- Presets min=120, sec=63 with MAX_MINUTES=99 -> display 99:59; start at 00:00 after load 0:0 -> stays IDLE.
- load asserted together with tick in RUNNING at 05:00 -> preset loaded, IDLE, no decrement.
